// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall scheduler: load-use stall, taken-branch flush countdown, memory-wait freeze.
// Optional HAZARD_STATS_EN adds saturating event counters for stalls, flushes and freezes.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W   = 5,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [REG_ADDR_W-1:0] ID_Rs,
   input  logic [REG_ADDR_W-1:0] ID_Rt,
   input  logic                  ID_UsesRt,
   input  logic                  EX_MemRead,
   input  logic [REG_ADDR_W-1:0] EX_Rt,
   input  logic                  Branch_Taken,
   input  logic                  Mem_Busy,
   output logic                  PC_Write,
   output logic                  IFID_Write,
   output logic                  IFID_Flush,
   output logic                  IDEX_Bubble,
   output logic                  Pipe_Freeze,
   output logic [1:0]            Ctrl_State
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0]           Stat_LoadStalls,
   output logic [15:0]           Stat_Flushes,
   output logic [15:0]           Stat_FreezeCycles
`endif
);

   typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic       load_use;

   assign load_use = EX_MemRead && (EX_Rt != '0) &&
                     ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

   assign Ctrl_State = state;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Priority chain: INIT > Mem_Busy > Branch_Taken > flush countdown > load-use > normal.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      PC_Write    = 1'b1;
      IFID_Write  = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Bubble = 1'b0;
      Pipe_Freeze = 1'b0;
      if (state == INIT) begin
         PC_Write    = 1'b0;
         IFID_Write  = 1'b0;
         IFID_Flush  = 1'b1;
         IDEX_Bubble = 1'b1;
         state_nxt   = RUN;
      end else if (Mem_Busy) begin
         PC_Write    = 1'b0;
         IFID_Write  = 1'b0;
         Pipe_Freeze = 1'b1;
      end else if (Branch_Taken) begin
         IFID_Flush  = 1'b1;
         IDEX_Bubble = 1'b1;
         cnt_nxt     = FLUSH_INIT;
         state_nxt   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if (state == FLUSH) begin
         IFID_Flush = 1'b1;
         cnt_nxt    = (cnt != 3'd0) ? cnt - 3'd1 : 3'd0;
         state_nxt  = (cnt <= 3'd1) ? RUN : FLUSH;
      end else if (load_use && state == RUN) begin
         PC_Write    = 1'b0;
         IFID_Write  = 1'b0;
         IDEX_Bubble = 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   // Events are recovered from the output pattern: a bubble with PC held is a load-use stall,
   // a bubble with PC loading is an accepted branch.
   logic ev_stall, ev_flush, ev_freeze;
   assign ev_stall  = (state != INIT) && IDEX_Bubble && !PC_Write;
   assign ev_flush  = (state != INIT) && IDEX_Bubble && PC_Write;
   assign ev_freeze = Pipe_Freeze;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         Stat_LoadStalls   <= '0;
         Stat_Flushes      <= '0;
         Stat_FreezeCycles <= '0;
      end else begin
         if (ev_stall && Stat_LoadStalls != 16'hFFFF)
            Stat_LoadStalls <= Stat_LoadStalls + 16'd1;
         if (ev_flush && Stat_Flushes != 16'hFFFF)
            Stat_Flushes <= Stat_Flushes + 16'd1;
         if (ev_freeze && Stat_FreezeCycles != 16'hFFFF)
            Stat_FreezeCycles <= Stat_FreezeCycles + 16'd1;
      end
   end
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall scheduler for the five-stage pipeline. Watches the ID and EX stages, the branch resolution signal and the data-memory busy line. Drives the write-enable and flush controls of the PC, the IF/ID pipeline register and the ID/EX pipeline register, so that load-use hazards stall, taken branches squash wrong-path fetches, and memory wait states freeze the machine.

## Interface

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- FLUSH_CYCLES, 1, IF/ID flush cycles per taken branch (legal range 1..7).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- ID_Rs  in  REG_ADDR_W  source register of the instruction in ID.
- ID_Rt  in  REG_ADDR_W  second source register of the instruction in ID.
- ID_UsesRt  in  1  ID instruction reads Rt.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_Rt  in  REG_ADDR_W  load destination register in EX.
- Branch_Taken  in  1  branch resolved taken this cycle (PC target valid).
- Mem_Busy  in  1  data memory not ready; whole pipeline must hold.
- PC_Write  out  1  PC register load enable.
- IFID_Write  out  1  IF/ID register load enable.
- IFID_Flush  out  1  IF/ID loads a NOP instead of the fetched instruction.
- IDEX_Bubble  out  1  ID/EX loads a NOP (control bits cleared).
- Pipe_Freeze  out  1  EX/MEM and MEM/WB must hold.
- Ctrl_State  out  2  current state (INIT=0, RUN=1, FLUSH=2).

## Operation

- Outputs are combinational from the registered state, the flush counter and the current inputs. Stalls and flushes act in the same cycle the condition is seen.
- Load-use hazard (LU) = EX_MemRead && EX_Rt != 0 && (EX_Rt == ID_Rs || (ID_UsesRt && EX_Rt == ID_Rt)).
- Priority in every state: reset > Mem_Busy > Branch_Taken > FLUSH countdown > LU > normal.
- Reset asserted: state = INIT, flush counter = 0, PC_Write = 0, IFID_Write = 0, IFID_Flush = 1, IDEX_Bubble = 1, Pipe_Freeze = 0.
- INIT lasts exactly one cycle after reset release, with the same outputs as during reset. Next state is RUN.
- Mem_Busy = 1, any state except INIT:
  - Outputs: PC_Write = 0, IFID_Write = 0, IFID_Flush = 0, IDEX_Bubble = 0, Pipe_Freeze = 1.
  - State and counter hold.
  - Branch_Taken and LU are ignored that cycle.
- Branch_Taken, RUN or FLUSH:
  - Outputs: PC_Write = 1, IFID_Write = 1, IFID_Flush = 1, IDEX_Bubble = 1.
  - Counter loads FLUSH_CYCLES-1.
  - Next state is FLUSH if FLUSH_CYCLES > 1, else RUN.
  - A branch arriving during FLUSH restarts the countdown.
- FLUSH with counter > 0, no branch:
  - Outputs: PC_Write = 1, IFID_Write = 1, IFID_Flush = 1, IDEX_Bubble = 0.
  - Counter decrements. When it reaches 0 the next state is RUN.
- LU in RUN: PC_Write = 0, IFID_Write = 0, IFID_Flush = 0, IDEX_Bubble = 1. State stays RUN. The inserted bubble clears EX_MemRead on the next cycle, so a single LU costs exactly one cycle.
- Normal: PC_Write = 1, IFID_Write = 1, all other controls 0.

## Timing

- Zero-cycle control latency: combinational input to output.
- State and counter update on posedge clock only. Reset is asynchronous on assertion.
- Load-use stall penalty: 1 cycle.
- Branch penalty: FLUSH_CYCLES cycles, plus any Mem_Busy cycles.
- Mem_Busy cycles extend any state by exactly their count. No event is lost except a Branch_Taken coinciding with Mem_Busy; the branch unit must hold Branch_Taken while Mem_Busy is high.
- Reset mid-flush: counter cleared, INIT re-entered, and no residual flush after INIT.

## Configuration

- HAZARD_STATS_EN defined: adds three outputs, each reset to 0 and saturating at 16'hFFFF:
  - Stat_LoadStalls [15:0]: +1 per LU stall cycle.
  - Stat_Flushes [15:0]: +1 per Branch_Taken accepted.
  - Stat_FreezeCycles [15:0]: +1 per Mem_Busy cycle outside INIT.
- HAZARD_STATS_EN undefined: these ports and counters do not exist. Control behaviour is identical.

## Test plan

- Reset held 3 cycles then released → IFID_Flush = 1 and IDEX_Bubble = 1 through reset and 1 INIT cycle. PC_Write = 1 from the second cycle after release.
- EX_MemRead = 1, EX_Rt = 5, ID_Rs = 5 → one cycle with PC_Write = 0, IFID_Write = 0, IDEX_Bubble = 1. Repeat with EX_Rt = 0 → no stall. Repeat with ID_Rt = 5 and ID_UsesRt = 0 → no stall.
- FLUSH_CYCLES = 3, single-cycle Branch_Taken → IFID_Flush = 1 for 3 consecutive cycles. IDEX_Bubble = 1 only in the first. Ctrl_State sequence is 1, 2, 2, 1.
- Mem_Busy = 1 for 4 cycles during FLUSH with counter = 1 → 4 frozen cycles with Pipe_Freeze = 1, then 1 flush cycle, then RUN.
- Branch_Taken and LU in the same cycle → branch outputs win (PC_Write = 1, IFID_Flush = 1). No extra stall cycle.
- With HAZARD_STATS_EN: 70000 forced LU cycles → Stat_LoadStalls saturates at 16'hFFFF. After reset all three stat outputs read 0.
